// File: rtl/ed_pkg.sv
// ed_pkg: shared defaults and sweep FSM state encoding for the ed_* blocks
package ed_pkg;
  localparam int ED_IN_BITS = 32;
  localparam int ED_SYNC_STAGES = 2;
  typedef enum logic [1:0] {
    ED_IDLE  = 2'd0,
    ED_ARMED = 2'd1,
    ED_RUN   = 2'd2,
    ED_DONE  = 2'd3
  } ed_state_e;
endpackage

// File: rtl/ed_trig_sync.sv
// ed_trig_sync: external trigger synchronizer with a one-cycle rising-edge pulse
module ed_trig_sync
  import ed_pkg::*;
#(
  parameter int SYNC_STAGES = ED_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_in,
  output logic trig_edge
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  // shift the pin through the chain and flag a 0->1 at the synchronized output
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], trig_in};
    prev_d = sync_q[SYNC_STAGES-1];
    trig_edge = sync_q[SYNC_STAGES-1] & ~prev_q;
  end
  // synchronizer and edge-history flops, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
endmodule

// File: rtl/ed_sweep_counter.sv
// ed_sweep_counter: inner/outer sweep timebase and comparator enable for ed_comp
module ed_sweep_counter
  import ed_pkg::*;
#(
  parameter int IN_BITS = ED_IN_BITS,
  parameter int SYNC_STAGES = ED_SYNC_STAGES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      trig_mode,
  input  logic                      ext_trig,
  input  logic signed [IN_BITS-1:0] period,
  input  logic signed [IN_BITS-1:0] n_reps,
  output logic signed [IN_BITS-1:0] count,
  output logic signed [IN_BITS-1:0] outer_count,
  output logic                      enable,
  output logic                      armed,
  output logic                      running,
  output logic                      wrap,
  output logic                      done,
  output logic                      cfg_err
);
  localparam logic signed [IN_BITS-1:0] ONE = IN_BITS'(1);
  ed_state_e state_q, state_d;
  logic signed [IN_BITS-1:0] count_q, count_d, outer_q, outer_d, per_q, per_d, nrep_q, nrep_d;
  logic wrap_q, wrap_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic trig_edge, last_cnt, last_rep, bad_cfg;
  ed_trig_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .trig_in  (ext_trig),
    .trig_edge(trig_edge)
  );
  assign last_cnt = count_q == per_q - ONE;
  assign last_rep = outer_q == nrep_q - ONE;
  assign bad_cfg = (period < ONE) || (n_reps < ONE);
  // next state, counters and shadows; wrap/done are pre-decoded from the next state
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    outer_d = outer_q;
    per_d = per_q;
    nrep_d = nrep_q;
    cfg_err_d = 1'b0;
    if (abort) begin
      state_d = ED_IDLE;
      count_d = '0;
      outer_d = '0;
    end else begin
      case (state_q)
        ED_IDLE: if (start) begin
          if (bad_cfg) cfg_err_d = 1'b1;
          else begin
            per_d = period;
            nrep_d = n_reps;
            state_d = trig_mode ? ED_ARMED : ED_RUN;
            count_d = '0;
            outer_d = '0;
          end
        end
        ED_ARMED: if (trig_edge) begin
          state_d = ED_RUN;
          count_d = '0;
          outer_d = '0;
        end
        ED_RUN: begin
          if (!last_cnt) count_d = count_q + ONE;
          else if (last_rep) state_d = ED_DONE;
          else begin
            count_d = '0;
            outer_d = outer_q + ONE;
          end
        end
        ED_DONE: begin
          state_d = ED_IDLE;
          count_d = '0;
          outer_d = '0;
        end
        default: state_d = ED_IDLE;
      endcase
    end
    wrap_d = (state_d == ED_RUN) && (count_d == per_d - ONE);
    done_d = state_d == ED_DONE;
  end
  // state, counter, shadow and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ED_IDLE;
      count_q <= '0;
      outer_q <= '0;
      per_q <= '0;
      nrep_q <= '0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      outer_q <= outer_d;
      per_q <= per_d;
      nrep_q <= nrep_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end
  assign count = count_q;
  assign outer_count = outer_q;
  assign enable = state_q == ED_RUN;
  assign running = state_q == ED_RUN;
  assign armed = state_q == ED_ARMED;
  assign wrap = wrap_q;
  assign done = done_q;
  assign cfg_err = cfg_err_q;
endmodule

// File: tb/tb_ed_sweep_counter.sv
// tb_ed_sweep_counter: scoreboard bench for the sweep timebase
module tb_ed_sweep_counter;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, trig_mode = 1'b0, ext_trig = 1'b0;
  logic signed [31:0] period = '0, n_reps = '0;
  logic signed [31:0] count, outer_count;
  logic enable, armed, running, wrap, done, cfg_err;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {
    int cyc;
    bit en, arm, wr, dn, ce;
    int cn, ou;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  ed_sweep_counter #(.IN_BITS(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .trig_mode(trig_mode),
    .ext_trig(ext_trig), .period(period), .n_reps(n_reps), .count(count),
    .outer_count(outer_count), .enable(enable), .armed(armed), .running(running),
    .wrap(wrap), .done(done), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // monitor: every cycle with visible activity must match the next scoreboard entry
  always @(negedge clk) begin
    if (rst_n && (enable || armed || done || cfg_err || wrap)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d en=%b arm=%b wrap=%b done=%b cerr=%b cnt=%0d out=%0d",
                 cyc, enable, armed, wrap, done, cfg_err, count, outer_count);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || enable !== e.en || running !== e.en || armed !== e.arm || wrap !== e.wr ||
            done !== e.dn || cfg_err !== e.ce || count !== e.cn || outer_count !== e.ou) begin
          errors++;
          $display("FAIL event got cyc=%0d en=%b run=%b arm=%b wrap=%b done=%b cerr=%b cnt=%0d out=%0d; exp cyc=%0d en=%b arm=%b wrap=%b done=%b cerr=%b cnt=%0d out=%0d",
                   cyc, enable, running, armed, wrap, done, cfg_err, count, outer_count,
                   e.cyc, e.en, e.arm, e.wr, e.dn, e.ce, e.cn, e.ou);
        end
      end
    end
  end
  task automatic push(input int c, input bit en, input bit arm, input bit wr, input bit dn,
                      input bit ce, input int cn, input int ou);
    exp_t x;
    x.cyc = c; x.en = en; x.arm = arm; x.wr = wr; x.dn = dn; x.ce = ce; x.cn = cn; x.ou = ou;
    sb.push_back(x);
  endtask
  task automatic push_sweep(input int base, input int p, input int n, input int len, input bit with_done);
    for (int k = 0; k < len; k++) push(base + k, 1, 0, (k % p) == p - 1, 0, 0, k % p, k / p);
    if (with_done) push(base + p * n, 0, 0, 0, 1, 0, p - 1, n - 1);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic drain(input string name, input int n);
    repeat (n) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s missing_events got %0d pending, exp 0 (next exp cyc=%0d)", name, sb.size(), sb[0].cyc);
      sb.delete();
    end
  endtask
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, act, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_outer"}, outer_count, 0);
    chk({tag, "_enable"}, enable, 0);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_armed"}, armed, 0);
    chk({tag, "_wrap"}, wrap, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
  endtask
  int c;
  initial begin
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    period = 4; n_reps = 3; trig_mode = 0;
    push_sweep(cyc + 1, 4, 3, 12, 1);
    pulse_start();
    drain("sw_p4n3", 16);
    period = 1; n_reps = 1;
    push_sweep(cyc + 1, 1, 1, 1, 1);
    pulse_start();
    drain("sw_p1n1", 4);
    period = 0; n_reps = 3;
    push(cyc + 1, 0, 0, 0, 0, 1, 0, 0);
    pulse_start();
    drain("cfg_p0", 4);
    period = 2; n_reps = 0;
    push(cyc + 1, 0, 0, 0, 0, 1, 0, 0);
    pulse_start();
    drain("cfg_n0", 4);
    period = -1; n_reps = 2;
    push(cyc + 1, 0, 0, 0, 0, 1, 0, 0);
    pulse_start();
    drain("cfg_neg", 4);
    period = 5; n_reps = 2; trig_mode = 1; c = cyc;
    for (int k = 1; k <= 12; k++) push(c + k, 0, 1, 0, 0, 0, 0, 0);
    push_sweep(c + 13, 5, 2, 10, 1);
    pulse_start();
    repeat (9) @(negedge clk);
    ext_trig = 1'b1;
    repeat (20) @(negedge clk);
    ext_trig = 1'b0;
    drain("trig_p5n2", 4);
    ext_trig = 1'b1;
    repeat (6) @(negedge clk);
    period = 2; n_reps = 2; c = cyc;
    for (int k = 1; k <= 10; k++) push(c + k, 0, 1, 0, 0, 0, 0, 0);
    push_sweep(c + 11, 2, 2, 4, 1);
    pulse_start();
    repeat (5) @(negedge clk);
    ext_trig = 1'b0;
    repeat (2) @(negedge clk);
    ext_trig = 1'b1;
    drain("trig_held_high", 12);
    ext_trig = 1'b0;
    drain("trig_low", 4);
    period = 4; n_reps = 3; trig_mode = 0; c = cyc;
    push_sweep(c + 1, 4, 3, 6, 0);
    pulse_start();
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_enable", enable, 0);
    chk("abort_count", count, 0);
    chk("abort_outer", outer_count, 0);
    drain("abort_run", 14);
    period = 3; n_reps = 2;
    push_sweep(cyc + 1, 3, 2, 6, 1);
    pulse_start();
    drain("after_abort", 10);
    push_sweep(cyc + 1, 3, 2, 6, 1);
    pulse_start();
    @(negedge clk);
    period = 7; n_reps = 5; trig_mode = 1;
    pulse_start();
    @(negedge clk);
    pulse_start();
    repeat (2) @(negedge clk);
    pulse_start();
    drain("shadowed", 6);
    trig_mode = 0;
    period = 2; n_reps = 2; c = cyc;
    push_sweep(c + 1, 2, 2, 4, 0);
    pulse_start();
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain("abort_terminal", 6);
    period = 4; n_reps = 3;
    push_sweep(cyc + 1, 4, 3, 5, 0);
    pulse_start();
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_idle("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drain("async_rst", 4);
    period = 2; n_reps = 1;
    push_sweep(cyc + 1, 2, 1, 2, 1);
    pulse_start();
    drain("post_rst", 5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
